// File: rtl/norm_round_if.sv
// norm_round_if: valid/ready handshake and data bundle around norm_round_stage.
// The slave modport is the stage's view; the master modport is the producer/consumer view.
interface norm_round_if #(
  parameter int EXP_W = 10
) ();
  logic             in_valid;
  logic             in_ready;
  logic             frac_inter_h_s;
  logic [74:0]      frac_inter;
  logic [EXP_W-1:0] exp_inter;
  logic             sign_inter;
  logic [1:0]       rnd_mode;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      result;
  logic [2:0]       flags;

  modport master (
    output in_valid, frac_inter_h_s, frac_inter, exp_inter, sign_inter, rnd_mode, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, frac_inter_h_s, frac_inter, exp_inter, sign_inter, rnd_mode, out_ready,
    output in_ready, out_valid, result, flags
  );
endinterface

// File: rtl/norm_round_stage.sv
// norm_round_stage: normalizes a 75-bit add-stage magnitude, rounds it to IEEE-754 single and packs it.
// Two-stage valid/ready pipeline; macro NORM_ROUND_FLAGS_EN builds the {overflow, underflow, inexact} flags.
module norm_round_stage #(
  parameter int EXP_W = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  norm_round_if.slave bus
);

  localparam logic [1:0] RM_RNE = 2'b00;
  localparam logic [1:0] RM_RTZ = 2'b01;
  localparam logic [1:0] RM_RUP = 2'b10;
  localparam logic [1:0] RM_RDN = 2'b11;

  logic                  s2_accept_s;
  logic                  in_ready_s;
  logic                  ld1_s;
  logic                  ld2_s;
  logic [6:0]            lzc_s;

  logic                  s1_v_q, s1_v_d;
  logic [73:0]           sh_q, sh_d;
  logic signed [EXP_W:0] exp_n_q, exp_n_d;
  logic                  s_q, s_d;
  logic                  zero_q, zero_d;
  logic [1:0]            rm_q, rm_d;

  logic [22:0]           man_s;
  logic                  g_s, st_s, inc_s, carry_s, ovf_s, unf_s;
  logic [23:0]           man_inc_s;
  logic [EXP_W+1:0]      exp_r_s;
  logic [31:0]           pack_s;

  logic                  s2_v_q, s2_v_d;
  logic [31:0]           result_q, result_d;

  // Stage 2 frees its slot when empty or when its result leaves this cycle.
  always_comb begin
    s2_accept_s = !s2_v_q || bus.out_ready;
    in_ready_s  = !s1_v_q || s2_accept_s;
    ld1_s       = in_ready_s && bus.in_valid;
    ld2_s       = s2_accept_s && s1_v_q;
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = s2_v_q;
  assign bus.result    = result_q;

  // Stage 1: leading-zero count, normalizing shift and exponent adjust.
  always_comb begin
    lzc_s = 7'd75;
    for (int i = 0; i < 75; i++) begin
      lzc_s = bus.frac_inter[i] ? 7'(74 - i) : lzc_s;
    end
    s1_v_d  = s1_v_q;
    sh_d    = sh_q;
    exp_n_d = exp_n_q;
    s_d     = s_q;
    zero_d  = zero_q;
    rm_d    = rm_q;
    if (ld1_s) begin
      s1_v_d  = 1'b1;
      sh_d    = 74'(bus.frac_inter << lzc_s);
      exp_n_d = {bus.exp_inter[EXP_W-1], bus.exp_inter} + (EXP_W+1)'(1) - (EXP_W+1)'(lzc_s);
      s_d     = bus.sign_inter ^ bus.frac_inter_h_s;
      zero_d  = (lzc_s == 7'd75);
      rm_d    = bus.rnd_mode;
    end else begin
      s1_v_d  = in_ready_s ? 1'b0 : s1_v_q;
    end
  end

  // Stage 2: round, detect range limits and pack.
  always_comb begin
    man_s = sh_q[73:51];
    g_s   = sh_q[50];
    st_s  = |sh_q[49:0];
    case (rm_q)
      RM_RNE:  inc_s = g_s & (st_s | man_s[0]);
      RM_RTZ:  inc_s = 1'b0;
      RM_RUP:  inc_s = ~s_q & (g_s | st_s);
      RM_RDN:  inc_s = s_q & (g_s | st_s);
      default: inc_s = 1'b0;
    endcase
    man_inc_s = {1'b0, man_s} + {23'd0, inc_s};
    carry_s   = man_inc_s[23];
    exp_r_s   = {exp_n_q[EXP_W], exp_n_q} + {{(EXP_W+1){1'b0}}, carry_s};
    ovf_s     = !exp_r_s[EXP_W+1] && (exp_r_s >= (EXP_W+2)'(255));
    unf_s     = exp_r_s[EXP_W+1] || (exp_r_s == (EXP_W+2)'(0));
    if (zero_q) begin
      pack_s = {rm_q == RM_RDN, 31'd0};
    end else if (ovf_s) begin
      case (rm_q)
        RM_RNE:  pack_s = {s_q, 31'h7F800000};
        RM_RTZ:  pack_s = {s_q, 31'h7F7FFFFF};
        RM_RUP:  pack_s = s_q ? 32'hFF7FFFFF : 32'h7F800000;
        RM_RDN:  pack_s = s_q ? 32'hFF800000 : 32'h7F7FFFFF;
        default: pack_s = {s_q, 31'h7F800000};
      endcase
    end else if (unf_s) begin
      pack_s = {s_q, 31'd0};
    end else begin
      pack_s = {s_q, exp_r_s[7:0], man_inc_s[22:0]};
    end
    s2_v_d   = s2_accept_s ? s1_v_q : s2_v_q;
    result_d = ld2_s ? pack_s : result_q;
  end

  // Pipeline registers; reset discards any beats in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q   <= 1'b0;
      sh_q     <= 74'd0;
      exp_n_q  <= (EXP_W+1)'(0);
      s_q      <= 1'b0;
      zero_q   <= 1'b0;
      rm_q     <= 2'b00;
      s2_v_q   <= 1'b0;
      result_q <= 32'd0;
    end else begin
      s1_v_q   <= s1_v_d;
      sh_q     <= sh_d;
      exp_n_q  <= exp_n_d;
      s_q      <= s_d;
      zero_q   <= zero_d;
      rm_q     <= rm_d;
      s2_v_q   <= s2_v_d;
      result_q <= result_d;
    end
  end

`ifdef NORM_ROUND_FLAGS_EN
  logic [2:0] flags_q, flags_d;
  logic [2:0] flags_s;

  // Flags follow the same priority as the packed result: zero, overflow, underflow, normal.
  always_comb begin
    if (zero_q) begin
      flags_s = 3'b000;
    end else if (ovf_s) begin
      flags_s = 3'b101;
    end else if (unf_s) begin
      flags_s = 3'b011;
    end else begin
      flags_s = {2'b00, g_s | st_s};
    end
    flags_d = ld2_s ? flags_s : flags_q;
  end

  // Flags register travels with result_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= 3'b000;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign bus.flags = flags_q;
`else
  assign bus.flags = 3'b000;
`endif

endmodule

// File: tb/tb_norm_round_stage.sv
// Self-checking bench for norm_round_stage: directed corner cases plus randomized traffic
// compared against an arithmetic reference model (remainder-vs-half rounding).
module tb_norm_round_stage;

  typedef struct packed {
    logic [74:0] frac;
    logic [9:0]  exp;
    logic        h;
    logic        sgn;
    logic [1:0]  rm;
  } beat_t;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;
  logic [34:0] expq[$];

  norm_round_if #(.EXP_W(10)) bus ();

  norm_round_stage #(.EXP_W(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic beat_t mk(input logic [74:0] f, input logic [9:0] e, input logic h,
                               input logic sg, input logic [1:0] rm);
    beat_t b;
    b.frac = f; b.exp = e; b.h = h; b.sgn = sg; b.rm = rm;
    return b;
  endfunction

  // Reference: value = frac * 2^(exp-73-bias); round by comparing the dropped remainder to half an ulp.
  function automatic logic [34:0] model(input beat_t b);
    int p, e;
    logic s, up, inx, inf;
    logic [74:0] kept, rem, half, unit;
    logic [31:0] r;
    logic [2:0] fl;
    s = b.sgn ^ b.h;
    p = -1;
    for (int i = 0; i < 75; i++) if (b.frac[i]) p = i;
    if (p < 0) return {3'b000, b.rm == 2'b11, 31'd0};
    e = int'($signed(b.exp)) + p - 73;
    if (p >= 23) begin
      unit = 75'(1) << (p - 23);
      kept = b.frac >> (p - 23);
      rem  = b.frac & (unit - 75'(1));
      half = unit >> 1;
    end else begin
      kept = b.frac << (23 - p);
      rem  = '0;
      half = '0;
    end
    inx = (rem != 0);
    case (b.rm)
      2'b00:   up = inx && ((rem > half) || ((rem == half) && kept[0]));
      2'b01:   up = 1'b0;
      2'b10:   up = inx && !s;
      default: up = inx && s;
    endcase
    kept = kept + 75'(up);
    if (kept == (75'(1) << 24)) begin
      kept = kept >> 1;
      e = e + 1;
    end
    if (e >= 255) begin
      inf = (b.rm == 2'b00) || (b.rm == 2'b10 && !s) || (b.rm == 2'b11 && s);
      r   = inf ? {s, 8'hFF, 23'd0} : {s, 8'hFE, 23'h7FFFFF};
      fl  = 3'b101;
    end else if (e <= 0) begin
      r  = {s, 31'd0};
      fl = 3'b011;
    end else begin
      r  = {s, 8'(e), kept[22:0]};
      fl = {2'b00, inx};
    end
`ifndef NORM_ROUND_FLAGS_EN
    fl = 3'b000;
`endif
    return {fl, r};
  endfunction

  function automatic beat_t rnd_beat();
    beat_t b;
    logic [95:0] w;
    w = {$urandom(), $urandom(), $urandom()};
    b.frac = 75'(w) >> $urandom_range(0, 78);
    if ($urandom_range(0, 15) == 0) b.frac = '0;
    b.exp = ($urandom_range(0, 3) == 0) ? 10'($urandom()) : 10'($urandom_range(0, 330));
    b.h   = 1'($urandom_range(0, 1));
    b.sgn = 1'($urandom_range(0, 1));
    b.rm  = 2'($urandom_range(0, 3));
    return b;
  endfunction

  // Drive one cycle at the falling edge, sample outputs 1 time unit later.
  task automatic cycle(input logic iv, input beat_t b, input logic ordy,
                       output logic ov, output logic [31:0] res, output logic [2:0] fl,
                       output logic ir);
    @(negedge clk);
    bus.in_valid       = iv;
    bus.frac_inter     = b.frac;
    bus.exp_inter      = b.exp;
    bus.frac_inter_h_s = b.h;
    bus.sign_inter     = b.sgn;
    bus.rnd_mode       = b.rm;
    bus.out_ready      = ordy;
    #1;
    ov  = bus.out_valid;
    res = bus.result;
    fl  = bus.flags;
    ir  = bus.in_ready;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.frac_inter = '0; bus.exp_inter = '0; bus.frac_inter_h_s = 1'b0;
    bus.sign_inter = 1'b0; bus.rnd_mode = 2'b00;
    repeat (2) @(negedge clk);
    #1;
    n_total++;
    if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got %0b want 0", bus.out_valid); else n_pass++;
    n_total++;
    if (bus.result !== 32'd0) $display("FAIL reset_result got %08h want 00000000", bus.result); else n_pass++;
    n_total++;
    if (bus.flags !== 3'b000) $display("FAIL reset_flags got %03b want 000", bus.flags); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_total++;
    if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got %0b want 1", bus.in_ready); else n_pass++;
  endtask

  task automatic test_directed();
    beat_t db[13];
    logic [31:0] dr[13];
    beat_t idle;
    logic [74:0] tie, rnd;
    logic [34:0] m;
    logic ov, ir;
    logic [31:0] res;
    logic [2:0] fl;
    idle = '0;
    tie = ((75'(1) << 25) - 75'(1)) << 49;
    rnd = (75'(1) << 73) | (75'(1) << 49) | 75'(1);
    db[0]  = mk(75'(1) << 73, 10'd127, 1'b0, 1'b0, 2'b00); dr[0]  = 32'h3F800000;
    db[1]  = mk(75'(0),       10'd127, 1'b0, 1'b0, 2'b00); dr[1]  = 32'h00000000;
    db[2]  = mk(75'(0),       10'd127, 1'b0, 1'b0, 2'b11); dr[2]  = 32'h80000000;
    db[3]  = mk(tie,          10'd127, 1'b0, 1'b0, 2'b00); dr[3]  = 32'h40000000;
    db[4]  = mk(75'(1) << 74, 10'd254, 1'b0, 1'b0, 2'b00); dr[4]  = 32'h7F800000;
    db[5]  = mk(75'(1) << 74, 10'd254, 1'b0, 1'b0, 2'b01); dr[5]  = 32'h7F7FFFFF;
    db[6]  = mk(75'(1) << 74, 10'd254, 1'b1, 1'b0, 2'b10); dr[6]  = 32'hFF7FFFFF;
    db[7]  = mk(75'(1) << 74, 10'd254, 1'b1, 1'b0, 2'b11); dr[7]  = 32'hFF800000;
    db[8]  = mk(75'(1) << 72, 10'd1,   1'b0, 1'b1, 2'b00); dr[8]  = 32'h80000000;
    db[9]  = mk(rnd,          10'd127, 1'b0, 1'b0, 2'b00); dr[9]  = 32'h3F800001;
    db[10] = mk(rnd,          10'd127, 1'b0, 1'b0, 2'b01); dr[10] = 32'h3F800000;
    db[11] = mk(rnd,          10'd127, 1'b0, 1'b1, 2'b10); dr[11] = 32'hBF800000;
    db[12] = mk(rnd,          10'd127, 1'b0, 1'b1, 2'b11); dr[12] = 32'hBF800001;
    for (int i = 0; i < 13; i++) begin
      m = model(db[i]);
      cycle(1'b1, db[i], 1'b1, ov, res, fl, ir);
      n_total++;
      if (ir !== 1'b1) $display("FAIL directed[%0d] in_ready got %0b want 1", i, ir); else n_pass++;
      cycle(1'b0, idle, 1'b1, ov, res, fl, ir);
      n_total++;
      if (ov !== 1'b0) $display("FAIL directed[%0d] early_valid got %0b want 0", i, ov); else n_pass++;
      cycle(1'b0, idle, 1'b1, ov, res, fl, ir);
      n_total++;
      if (ov !== 1'b1) $display("FAIL directed[%0d] out_valid got %0b want 1", i, ov); else n_pass++;
      n_total++;
      if (res !== dr[i]) $display("FAIL directed[%0d] result got %08h want %08h", i, res, dr[i]); else n_pass++;
      n_total++;
      if (fl !== m[34:32]) $display("FAIL directed[%0d] flags got %03b want %03b", i, fl, m[34:32]); else n_pass++;
    end
  endtask

  task automatic test_back_pressure();
    beat_t bb[4];
    logic [34:0] e;
    logic ov, ir, ordy, held_v;
    logic [31:0] res, held_r;
    logic [2:0] fl, held_f;
    int idx, got;
    expq.delete();
    for (int i = 0; i < 4; i++) bb[i] = mk(75'(1) << 73 | 75'($urandom()), 10'(100 + i), 1'b0, 1'b0, 2'b00);
    idx = 0; got = 0; held_v = 1'b0; held_r = '0; held_f = '0;
    for (int c = 0; c < 40 && (idx < 4 || got < 4); c++) begin
      ordy = (c >= 3);
      cycle(idx < 4, bb[idx < 4 ? idx : 0], ordy, ov, res, fl, ir);
      if (c == 2) begin
        n_total++;
        if (idx != 2) $display("FAIL bp_accepted got %0d want 2", idx); else n_pass++;
        n_total++;
        if (ir !== 1'b0) $display("FAIL bp_in_ready got %0b want 0", ir); else n_pass++;
      end
      if (held_v) begin
        n_total++;
        if (ov !== 1'b1 || res !== held_r || fl !== held_f)
          $display("FAIL bp_hold got %0b/%08h/%03b want 1/%08h/%03b", ov, res, fl, held_r, held_f);
        else n_pass++;
      end
      if (ov && ordy) begin
        e = expq.pop_front();
        got++;
        n_total++;
        if ({fl, res} !== e) $display("FAIL bp_beat%0d got %03b/%08h want %03b/%08h", got, fl, res, e[34:32], e[31:0]);
        else n_pass++;
      end
      if (idx < 4 && ir) begin
        expq.push_back(model(bb[idx]));
        idx++;
      end
      held_v = ov && !ordy; held_r = res; held_f = fl;
    end
    n_total++;
    if (got != 4) $display("FAIL bp_count got %0d want 4", got); else n_pass++;
  endtask

  task automatic test_random();
    beat_t b;
    logic [34:0] e;
    logic iv, ov, ir, ordy, held_v;
    logic [31:0] res, held_r;
    logic [2:0] fl, held_f;
    int bad;
    expq.delete();
    held_v = 1'b0; held_r = '0; held_f = '0; bad = 0;
    for (int c = 0; c < 420; c++) begin
      iv   = (c < 400) && ($urandom_range(0, 3) != 0);
      ordy = (c >= 400) || ($urandom_range(0, 3) != 0);
      b    = rnd_beat();
      cycle(iv, b, ordy, ov, res, fl, ir);
      if (held_v) begin
        n_total++;
        if (ov !== 1'b1 || res !== held_r || fl !== held_f)
          $display("FAIL rand_hold c%0d got %0b/%08h want 1/%08h", c, ov, res, held_r);
        else n_pass++;
      end
      if (ov && ordy) begin
        n_total++;
        if (expq.size() == 0) begin
          $display("FAIL rand_extra c%0d got %08h want no output", c, res);
        end else begin
          e = expq.pop_front();
          if ({fl, res} !== e) begin
            bad++;
            if (bad <= 10) $display("FAIL rand_beat c%0d got %03b/%08h want %03b/%08h", c, fl, res, e[34:32], e[31:0]);
          end else n_pass++;
        end
      end
      if (iv && ir) expq.push_back(model(b));
      held_v = ov && !ordy; held_r = res; held_f = fl;
    end
    n_total++;
    if (expq.size() != 0) $display("FAIL rand_drain got %0d left want 0", expq.size()); else n_pass++;
  endtask

  task automatic test_reset_midflight();
    beat_t b, xb;
    logic ov, ir;
    logic [31:0] res;
    logic [2:0] fl;
    expq.delete();
    b = mk(75'(1) << 73, 10'd127, 1'b0, 1'b0, 2'b00);
    cycle(1'b1, b, 1'b0, ov, res, fl, ir);
    cycle(1'b1, b, 1'b0, ov, res, fl, ir);
    bus.in_valid = 1'b0;
    @(negedge clk);
    #1;
    n_total++;
    if (bus.out_valid !== 1'b1) $display("FAIL rstmid_inflight got %0b want 1", bus.out_valid); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (bus.out_valid !== 1'b0) $display("FAIL rstmid_out_valid got %0b want 0", bus.out_valid); else n_pass++;
    n_total++;
    if (bus.result !== 32'd0) $display("FAIL rstmid_result got %08h want 00000000", bus.result); else n_pass++;
    n_total++;
    if (bus.flags !== 3'b000) $display("FAIL rstmid_flags got %03b want 000", bus.flags); else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    xb = 'x;
    for (int c = 0; c < 6; c++) begin
      cycle(1'b0, xb, 1'b1, ov, res, fl, ir);
      n_total++;
      if (ov !== 1'b0) $display("FAIL rstmid_stale c%0d got %0b want 0", c, ov); else n_pass++;
    end
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    test_reset();
    test_directed();
    test_back_pressure();
    test_random();
    test_reset_midflight();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
